// File: rtl/mdu_hilo_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at launch, held pending, and committed when the busy countdown expires.
module mdu_hilo_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDU_Op,
  input  logic        Start,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor_u, quot_u, rem_u;
  logic [31:0] a_mag, b_mag, mag_q, mag_r, quot_s, rem_s;
  logic [31:0] res_hi, res_lo;
  logic        launch, is_div;

  // Signed division goes through magnitudes so that 0x80000000 / -1 wraps cleanly;
  // a zero divisor is replaced by 1 and the result discarded in favour of current HI/LO.
  always_comb begin
    prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u    = {32'd0, A} * {32'd0, B};
    divisor_u = (B == 32'd0) ? 32'd1 : B;
    quot_u    = A / divisor_u;
    rem_u     = A % divisor_u;
    a_mag     = A[31] ? (32'd0 - A) : A;
    b_mag     = B[31] ? (32'd0 - B) : divisor_u;
    mag_q     = a_mag / b_mag;
    mag_r     = a_mag % b_mag;
    quot_s    = (A[31] ^ B[31]) ? (32'd0 - mag_q) : mag_q;
    rem_s     = A[31] ? (32'd0 - mag_r) : mag_r;

    res_hi = hi_q;
    res_lo = lo_q;
    case (MDU_Op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (B != 32'd0) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OP_DIVU: begin
        if (B != 32'd0) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    launch  = Start && !IntReq && (MDU_Op >= OP_MULT) && (MDU_Op <= OP_DIVU);
    is_div  = (MDU_Op == OP_DIV) || (MDU_Op == OP_DIVU);

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          p_hi_d  = res_hi;
          p_lo_d  = res_lo;
          cnt_d   = is_div ? DIV_N : MULT_N;
          state_d = S_RUN;
        end else if (!IntReq && MDU_Op == OP_MTHI) begin
          hi_d = A;
        end else if (!IntReq && MDU_Op == OP_MTLO) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd1) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
    end
  end

  assign Busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed vector table, hand-written
// multi-cycle corner sequences, and randomized ops against an arithmetic model.
module tb_mdu_hilo_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDU_Op;
  logic        Start, IntReq;
  logic        Busy;
  logic [31:0] HI, LO;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_hi, model_lo;

  mdu_hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDU_Op(MDU_Op),
    .Start(Start), .IntReq(IntReq), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    A = 32'd0; B = 32'd0; MDU_Op = 3'd0; Start = 1'b0; IntReq = 1'b0;
  endtask

  // Drive one op for one cycle, then count busy cycles (bounded).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic start, input logic intreq, output int cyc);
    @(negedge clk);
    A = a; B = b; MDU_Op = op; Start = start; IntReq = intreq;
    @(negedge clk);
    idleInputs();
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Behavioural reference: updates model_hi/model_lo from the architectural rules.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic intreq, output int cyc);
    int sa, sb;
    longint la, lb, p;
    longint unsigned ua, ub, pu;
    sa = a; sb = b; la = sa; lb = sb;
    ua = {32'd0, a}; ub = {32'd0, b};
    cyc = 0;
    if (intreq) return;
    case (op)
      3'd1: begin p = la * lb; {model_hi, model_lo} = p; cyc = MC; end
      3'd2: begin pu = ua * ub; {model_hi, model_lo} = pu; cyc = MC; end
      3'd3: begin
        cyc = DC;
        if (b != 0) begin
          p = la / lb; model_lo = p[31:0];
          p = la % lb; model_hi = p[31:0];
        end
      end
      3'd4: begin
        cyc = DC;
        if (b != 0) begin
          pu = ua / ub; model_lo = pu[31:0];
          pu = ua % ub; model_hi = pu[31:0];
        end
      end
      3'd5: model_hi = a;
      3'd6: model_lo = a;
      default: ;
    endcase
  endtask

  initial begin
    int cyc;
    int exp_cyc;
    logic [2:0] op;
    logic [31:0] ra, rb;
    logic ri;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, MC};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[3] = '{3'd4, 32'd7,        32'd0,          32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000, DC};
    vecs[5] = '{3'd5, 32'h12345678, 32'd0,          32'h12345678, 32'h80000000, 0};
    vecs[6] = '{3'd6, 32'h9ABCDEF0, 32'd0,          32'h12345678, 32'h9ABCDEF0, 0};
    vecs[7] = '{3'd4, 32'd256,      32'd7,          32'h00000004, 32'h00000024, DC};
    vecs[8] = '{3'd3, 32'd7,        32'hFFFFFFFE,   32'h00000001, 32'hFFFFFFFD, DC};
    vecs[9] = '{3'd3, 32'd0,        32'd0,          32'h00000001, 32'hFFFFFFFD, DC};

    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset hi", HI, 32'd0);
    checkOutput("reset lo", LO, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, (vecs[i].op <= 3'd4), 1'b0, cyc);
      checkOutput($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cyc);
      checkOutput($sformatf("vec%0d hi", i), HI, vecs[i].exp_hi);
      checkOutput($sformatf("vec%0d lo", i), LO, vecs[i].exp_lo);
    end

    // Launch suppressed by IntReq
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b1, 1'b1, cyc);
    checkOutput("intreq launch cycles", cyc, 0);
    checkOutput("intreq launch hi", HI, 32'h00000001);
    checkOutput("intreq launch lo", LO, 32'hFFFFFFFD);

    // mthi while busy, restart attempt mid-run and at the commit cycle
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDU_Op = 3'd1; Start = 1'b1;
    @(negedge clk);
    idleInputs();
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 1) begin MDU_Op = 3'd5; A = 32'hDEADBEEF; end
      else if (cyc == 2) begin MDU_Op = 3'd3; Start = 1'b1; A = 32'd100; B = 32'd7; end
      else if (cyc == MC) begin MDU_Op = 3'd1; Start = 1'b1; A = 32'd5; B = 32'd5; end
      else idleInputs();
      @(negedge clk);
      idleInputs();
    end
    checkOutput("busy-ignore cycles", cyc, MC);
    checkOutput("busy-ignore hi", HI, 32'd0);
    checkOutput("busy-ignore lo", LO, 32'd12);
    @(negedge clk);
    checkOutput("no restart busy", {31'd0, Busy}, 32'd0);
    checkOutput("no restart lo", LO, 32'd12);

    // IntReq during RUN does not cancel
    @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'd9; MDU_Op = 3'd1; Start = 1'b1;
    @(negedge clk);
    idleInputs();
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) IntReq = 1'b1;
      @(negedge clk);
      idleInputs();
    end
    checkOutput("intreq run cycles", cyc, MC);
    checkOutput("intreq run hi", HI, 32'hFFFFFFFF);
    checkOutput("intreq run lo", LO, 32'hFFFFFFF7);

    // Randomized ops against the reference model
    model_hi = HI === 32'hFFFFFFFF ? 32'hFFFFFFFF : 32'd0;
    model_lo = 32'hFFFFFFF7;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        1: rb = 32'd0;
        2: begin ra = ra & 32'hFF; rb = rb & 32'hF; end
        3: rb = rb & 32'hFFFF;
        default: ;
      endcase
      ri = ($urandom_range(0, 7) == 0);
      modelOp(op, ra, rb, ri, exp_cyc);
      applyStimulus(op, ra, rb, 1'b1, ri, cyc);
      checkOutput($sformatf("rand%0d op%0d cycles", i, op), cyc, exp_cyc);
      checkOutput($sformatf("rand%0d op%0d hi", i, op), HI, model_hi);
      checkOutput($sformatf("rand%0d op%0d lo", i, op), LO, model_lo);
    end

    // Reset in the middle of RUN abandons the op
    @(negedge clk);
    A = 32'd3; B = 32'd4; MDU_Op = 3'd1; Start = 1'b1;
    @(negedge clk);
    idleInputs();
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 3) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    checkOutput("midrun reset cycles", cyc, 3);
    checkOutput("midrun reset hi", HI, 32'd0);
    checkOutput("midrun reset lo", LO, 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("post reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("post reset hi", HI, 32'd0);
    checkOutput("post reset lo", LO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
